// File: rtl/csa_result_fifo_if.sv
// Handshake bundle between the carry-skip adder producer, the result FIFO
// and its consumer. The FIFO uses the slave view; a producer/consumer pair
// (or a bench) uses the master view.
interface csa_result_fifo_if #(
  parameter int CNT_W = 3
);
  // producer side
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_sum;
  logic             in_cout;
  logic             in_a_msb;
  logic             in_b_msb;
  // consumer side
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_sum;
  logic             out_cout;
  logic             out_zero;
  logic             out_ovf;
  // status
  logic [CNT_W-1:0] fill;
  logic [7:0]       drop_cnt;

  modport master (
    output in_valid, in_sum, in_cout, in_a_msb, in_b_msb, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_zero, out_ovf,
           fill, drop_cnt
  );

  modport slave (
    input  in_valid, in_sum, in_cout, in_a_msb, in_b_msb, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_zero, out_ovf,
           fill, drop_cnt
  );
endinterface

// File: rtl/csa_result_fifo.sv
// Capture stage behind the 8-bit carry-skip adder. Each accepted result is
// tagged with zero / signed-overflow flags and queued in a small FIFO.
// The input side never stalls the producer: a result offered while the FIFO
// is full is discarded and counted in a saturating drop counter.
// Ready/valid are derived from the registered fill only, so there is no
// combinational path from out_ready to in_ready and no fall-through.
module csa_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  csa_result_fifo_if.slave    bus
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       zero;
    logic       ovf;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_fill;
  logic [7:0]       r_drop_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  entry_t           w_entry;
  entry_t           w_head;

  assign w_full  = (r_fill == FULL_CNT);
  assign w_empty = (r_fill == '0);
  // A pop in the same cycle does not free a slot for a push: full is registered.
  assign w_push  = bus.in_valid & ~w_full;
  assign w_pop   = bus.out_ready & ~w_empty;
  assign w_drop  = bus.in_valid & w_full;

  // Flag the incoming result: overflow when both operands share a sign and
  // the sum's sign differs from it.
  always_comb begin
    w_entry      = '0;
    w_entry.sum  = bus.in_sum;
    w_entry.cout = bus.in_cout;
    w_entry.zero = (bus.in_sum == 8'h00);
    w_entry.ovf  = (bus.in_a_msb == bus.in_b_msb) & (bus.in_sum[7] != bus.in_a_msb);
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + CNT_W'(1);
        2'b01:   r_fill <= r_fill - CNT_W'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Count results rejected because the FIFO was full, sticking at 8'hFF.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Entry storage; contents need no reset because fill masks stale slots.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head = r_mem[r_rd_ptr];

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.out_sum   = w_empty ? 8'h00 : w_head.sum;
  assign bus.out_cout  = w_empty ? 1'b0  : w_head.cout;
  assign bus.out_zero  = w_empty ? 1'b0  : w_head.zero;
  assign bus.out_ovf   = w_empty ? 1'b0  : w_head.ovf;
  assign bus.fill      = r_fill;
  assign bus.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_csa_result_fifo.sv
// Bench for csa_result_fifo: directed scenarios followed by random traffic,
// all checked against a queue-based reference model that derives results
// and flags from the adder operands with plain integer arithmetic.
module tb_csa_result_fifo;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csa_result_fifo_if #(.CNT_W(CNT_W)) bus ();

  csa_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       zero;
    logic       ovf;
  } ent_t;

  ent_t model_q[$];
  int   model_drop = 0;
  int   checks     = 0;
  int   failures   = 0;

  localparam logic [7:0] T3_A   [5] = '{8'h58, 8'h35, 8'h4A, 8'hA6, 8'h73};
  localparam logic [7:0] T3_B   [5] = '{8'hF4, 8'h0F, 8'hC8, 8'hD4, 8'hCC};
  localparam logic [7:0] T3_SUM [5] = '{8'h4C, 8'h44, 8'h12, 8'h7A, 8'h3F};
  localparam logic       T3_OVF [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result of an 8-bit add, flags taken from true signed range.
  function automatic ent_t make_entry(input logic [7:0] a, input logic [7:0] b);
    ent_t       e;
    logic [8:0] t;
    int         s;
    t      = {1'b0, a} + {1'b0, b};
    s      = int'($signed(a)) + int'($signed(b));
    e.sum  = t[7:0];
    e.cout = t[8];
    e.zero = (t[7:0] == 8'h00);
    e.ovf  = (s > 127) || (s < -128);
    return e;
  endfunction

  task automatic check_all();
    ent_t h;
    bit   empty;
    empty = (model_q.size() == 0);
    if (empty) h = '{8'h00, 1'b0, 1'b0, 1'b0};
    else       h = model_q[0];
    chk("in_ready",  32'(bus.in_ready),  32'(model_q.size() < DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(!empty));
    chk("fill",      32'(bus.fill),      32'(model_q.size()));
    chk("drop_cnt",  32'(bus.drop_cnt),  32'(model_drop));
    chk("out_sum",   32'(bus.out_sum),   32'(h.sum));
    chk("out_cout",  32'(bus.out_cout),  32'(h.cout));
    chk("out_zero",  32'(bus.out_zero),  32'(h.zero));
    chk("out_ovf",   32'(bus.out_ovf),   32'(h.ovf));
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b, input bit ordy);
    ent_t e;
    bit   can_push;
    bit   can_pop;
    e             = make_entry(a, b);
    rst_n         = 1'b1;
    bus.in_valid  = v;
    bus.in_sum    = e.sum;
    bus.in_cout   = e.cout;
    bus.in_a_msb  = a[7];
    bus.in_b_msb  = b[7];
    bus.out_ready = ordy;
    can_push = v && (model_q.size() < DEPTH);
    can_pop  = ordy && (model_q.size() > 0);
    if (v && !can_push && model_drop < 255) model_drop++;
    if (can_pop)  void'(model_q.pop_front());
    if (can_push) model_q.push_back(e);
    @(negedge clk);
    check_all();
  endtask

  // Hold reset for n clocks with traffic offered on both sides.
  task automatic reset_cycles(input int n);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_sum    = 8'($urandom);
    bus.in_cout   = 1'b1;
    bus.in_a_msb  = 1'b1;
    bus.in_b_msb  = 1'b1;
    repeat (n) @(negedge clk);
    model_q.delete();
    model_drop = 0;
    check_all();
  endtask

  initial begin
    // 1: reset with in_valid held high
    reset_cycles(2);
    chk("rst_fill",      32'(bus.fill),      32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_drop",      32'(bus.drop_cnt),  32'd0);

    // 2: single push, visible one cycle later
    step(1'b1, 8'hA0, 8'hA4, 1'b0);
    chk("t2_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_sum",   32'(bus.out_sum),   32'h44);
    chk("t2_cout",  32'(bus.out_cout),  32'd1);
    chk("t2_ovf",   32'(bus.out_ovf),   32'd1);
    chk("t2_zero",  32'(bus.out_zero),  32'd0);
    step(1'b0, 8'h00, 8'h00, 1'b1);

    // 3: ordering across pointer wrap with interleaved pops
    step(1'b1, T3_A[0], T3_B[0], 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("t3_sum", 32'(bus.out_sum), 32'(T3_SUM[k]));
      chk("t3_ovf", 32'(bus.out_ovf), 32'(T3_OVF[k]));
      if (k < 4) step(1'b1, T3_A[k+1], T3_B[k+1], 1'b1);
      else       step(1'b0, 8'h00, 8'h00, 1'b1);
    end

    // 4: fill up, overflow into drops, then pop-while-full blocks the push
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 8'(k * 17 + 3), 8'(k * 29 + 5), 1'b0);
      if (k == 3) begin
        chk("t4_full_fill",  32'(bus.fill),     32'd4);
        chk("t4_full_ready", 32'(bus.in_ready), 32'd0);
      end
    end
    chk("t4_drop2", 32'(bus.drop_cnt), 32'd2);
    step(1'b1, 8'h11, 8'h22, 1'b1);
    chk("t4_fill3", 32'(bus.fill),     32'd3);
    chk("t4_drop3", 32'(bus.drop_cnt), 32'd3);
    repeat (3) step(1'b0, 8'h00, 8'h00, 1'b1);

    // 5: steady push+pop at fill=2
    step(1'b1, 8'h01, 8'h02, 1'b0);
    step(1'b1, 8'h03, 8'h04, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'b1);
      chk("t5_fill", 32'(bus.fill), 32'd2);
    end
    repeat (2) step(1'b0, 8'h00, 8'h00, 1'b1);

    // 6: zero flag, then reset with entries stored
    step(1'b1, 8'h80, 8'h80, 1'b0);
    chk("t6_zero", 32'(bus.out_zero), 32'd1);
    chk("t6_ovf",  32'(bus.out_ovf),  32'd1);
    chk("t6_cout", 32'(bus.out_cout), 32'd1);
    step(1'b1, 8'h10, 8'h20, 1'b0);
    step(1'b1, 8'h30, 8'h40, 1'b0);
    chk("t6_fill3", 32'(bus.fill), 32'd3);
    reset_cycles(1);
    chk("t6_rst_fill",  32'(bus.fill),      32'd0);
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);

    // Random: producer-heavy phase drives drop_cnt into saturation
    for (int k = 0; k < 300; k++)
      step(1'b1, 8'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0));
    chk("sat_drop", 32'(bus.drop_cnt), 32'hFF);

    // Random: balanced traffic, including zero sums
    for (int k = 0; k < 300; k++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'(9'h100 - {1'b0, a}) : 8'($urandom);
      step(1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
